fp_add_normalize: RTL and testbench

Floating-point adder stage that sits directly downstream of the operand-alignment stage. It takes one pair of aligned significands with the operation select, result sign and result exponent. It adds or subtracts the significands, then normalizes the result with a multi-cycle shift state machine, one bit per cycle. It delivers sign, exponent, normalized significand and status flags through a valid/ready handshake.

---
 rtl/fp_add_normalize.sv | 156 +++++++++++++++
 tb/tb_fp_add_normalize.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/fp_add_normalize.sv
// Floating-point add/subtract stage following operand alignment: one-cycle
// significand add, then a bit-serial normalization FSM behind a valid/ready handshake.
module fp_add_normalize #(
  parameter int E_WIDTH = 8,
  parameter int M_WIDTH = 23
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [M_WIDTH-1:0] align_A,
  input  logic [M_WIDTH-1:0] align_B,
  input  logic               add_sub,
  input  logic               sign_res,
  input  logic [E_WIDTH-1:0] exp_res,
  output logic               out_valid,
  input  logic               out_ready,
  output logic               sign_out,
  output logic [E_WIDTH-1:0] exp_out,
  output logic [M_WIDTH-1:0] mant_out,
  output logic               overflow,
  output logic               zero
);

  typedef enum logic [1:0] {IDLE, ADD, NORM, DONE} state_t;

  localparam logic [E_WIDTH:0] EXP_MAX = {1'b0, {E_WIDTH{1'b1}}};
  localparam logic [E_WIDTH:0] EXP_ONE = (E_WIDTH+1)'(1);

  state_t state, state_next;

  logic [M_WIDTH-1:0] a_q, b_q;
  logic               add_sub_q, sign_q;
  logic [E_WIDTH-1:0] exp_q;

  logic [M_WIDTH:0]   sum;
  logic [E_WIDTH:0]   e;
  logic               sign_w;

  logic               accept, a_lt_b;
  logic               sum_zero, carry, normed, uflow, norm_stop;
  logic [E_WIDTH:0]   e_inc;

  assign in_ready  = (state == IDLE);
  assign accept    = in_valid && in_ready;
  assign a_lt_b    = (a_q < b_q);
  assign sum_zero  = (sum == '0);
  assign carry     = sum[M_WIDTH];
  assign normed    = sum[M_WIDTH-1];
  assign uflow     = (e <= EXP_ONE);
  assign norm_stop = sum_zero || carry || normed || uflow;
  assign e_inc     = e + EXP_ONE;

  // NOTE: sequential state uses non-blocking (<=) so every flop samples
  // pre-edge values; blocking (=) here would create order-dependent races.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_next;
  end

  // NOTE: state_next gets a default before the case so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state_next = state;
    case (state)
      IDLE: if (accept)                 state_next = ADD;
      ADD:                              state_next = NORM;
      NORM: if (norm_stop)              state_next = DONE;
      DONE: if (out_valid && out_ready) state_next = IDLE;
      default:                          state_next = IDLE;
    endcase
  end

  // NOTE: the working registers are a handful of flops rather than a memory
  // array, so they share the async reset and an aborted operation leaves no residue.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      a_q       <= '0;
      b_q       <= '0;
      add_sub_q <= 1'b0;
      sign_q    <= 1'b0;
      exp_q     <= '0;
      sum       <= '0;
      e         <= '0;
      sign_w    <= 1'b0;
      out_valid <= 1'b0;
      sign_out  <= 1'b0;
      exp_out   <= '0;
      mant_out  <= '0;
      overflow  <= 1'b0;
      zero      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            a_q       <= align_A;
            b_q       <= align_B;
            add_sub_q <= add_sub;
            sign_q    <= sign_res;
            exp_q     <= exp_res;
          end
        end
        ADD: begin
          if (!add_sub_q)  sum <= {1'b0, a_q} + {1'b0, b_q};
          else if (a_lt_b) sum <= {1'b0, b_q} - {1'b0, a_q};
          else             sum <= {1'b0, a_q} - {1'b0, b_q};
          sign_w <= sign_q ^ (add_sub_q & a_lt_b);
          e      <= {1'b0, exp_q};
        end
        NORM: begin
          if (norm_stop) begin
            out_valid <= 1'b1;
            overflow  <= 1'b0;
            zero      <= 1'b0;
            sign_out  <= sign_w;
          end
          if (sum_zero) begin
            zero     <= 1'b1;
            sign_out <= 1'b0;
            exp_out  <= '0;
            mant_out <= '0;
          end else if (carry) begin
            // Carry out of the MSB: shift right once and bump the exponent.
            if (e_inc >= EXP_MAX) begin
              exp_out  <= '1;
              mant_out <= '0;
              overflow <= 1'b1;
            end else begin
              exp_out  <= e_inc[E_WIDTH-1:0];
              mant_out <= sum[M_WIDTH:1];
            end
          end else if (normed) begin
            exp_out  <= e[E_WIDTH-1:0];
            mant_out <= sum[M_WIDTH-1:0];
          end else if (uflow) begin
            exp_out  <= '0;
            mant_out <= sum[M_WIDTH-1:0];
          end else begin
            sum <= sum << 1;
            e   <= e - EXP_ONE;
          end
        end
        DONE: begin
          // Data outputs hold their last value; only valid and flags drop.
          if (out_ready) begin
            out_valid <= 1'b0;
            overflow  <= 1'b0;
            zero      <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_fp_add_normalize.sv
// Directed self-checking bench for fp_add_normalize: hand-computed vectors,
// latency, backpressure and asynchronous reset checks.
module tb_fp_add_normalize;

  localparam int E_WIDTH = 8;
  localparam int M_WIDTH = 23;

  logic               clk;
  logic               rst;
  logic               in_valid;
  logic               in_ready;
  logic [M_WIDTH-1:0] align_A;
  logic [M_WIDTH-1:0] align_B;
  logic               add_sub;
  logic               sign_res;
  logic [E_WIDTH-1:0] exp_res;
  logic               out_valid;
  logic               out_ready;
  logic               sign_out;
  logic [E_WIDTH-1:0] exp_out;
  logic [M_WIDTH-1:0] mant_out;
  logic               overflow;
  logic               zero;

  int n_cmp = 0;
  int n_err = 0;

  fp_add_normalize #(.E_WIDTH(E_WIDTH), .M_WIDTH(M_WIDTH)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .align_A   (align_A),
    .align_B   (align_B),
    .add_sub   (add_sub),
    .sign_res  (sign_res),
    .exp_res   (exp_res),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sign_out  (sign_out),
    .exp_out   (exp_out),
    .mant_out  (mant_out),
    .overflow  (overflow),
    .zero      (zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_cmp++;
    assert (obs === exp_v) else begin
      n_err++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp_v);
    end
  endtask

  // Presents one operand set and returns at the negedge after the handshake edge.
  task automatic send(input logic [M_WIDTH-1:0] a, input logic [M_WIDTH-1:0] b,
                      input logic as, input logic s, input logic [E_WIDTH-1:0] ex);
    @(negedge clk);
    align_A  = a;
    align_B  = b;
    add_sub  = as;
    sign_res = s;
    exp_res  = ex;
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic wait_result(input string tag, input int exp_lat);
    int lat;
    lat = 0;
    while (!out_valid && lat < 200) begin
      @(negedge clk);
      lat++;
    end
    check({tag, "_latency"}, 32'(lat), 32'(exp_lat));
  endtask

  task automatic check_result(input string tag, input logic s, input logic [E_WIDTH-1:0] ex,
                              input logic [M_WIDTH-1:0] m, input logic ov, input logic z);
    check({tag, "_valid"},    32'(out_valid), 32'd1);
    check({tag, "_sign"},     32'(sign_out),  32'(s));
    check({tag, "_exp"},      32'(exp_out),   32'(ex));
    check({tag, "_mant"},     32'(mant_out),  32'(m));
    check({tag, "_overflow"}, 32'(overflow),  32'(ov));
    check({tag, "_zero"},     32'(zero),      32'(z));
    check({tag, "_in_ready"}, 32'(in_ready),  32'd0);
  endtask

  // With out_ready high the result is a one-cycle pulse; stage returns to IDLE.
  task automatic check_release(input string tag);
    @(negedge clk);
    check({tag, "_valid_clr"}, 32'(out_valid), 32'd0);
    check({tag, "_flags_clr"}, 32'({overflow, zero}), 32'd0);
    check({tag, "_ready_ret"}, 32'(in_ready), 32'd1);
  endtask

  task automatic run_op(input string tag,
                        input logic [M_WIDTH-1:0] a, input logic [M_WIDTH-1:0] b,
                        input logic as, input logic s, input logic [E_WIDTH-1:0] ex,
                        input int lat, input logic es, input logic [E_WIDTH-1:0] ee,
                        input logic [M_WIDTH-1:0] em, input logic eov, input logic ez);
    send(a, b, as, s, ex);
    wait_result(tag, lat);
    check_result(tag, es, ee, em, eov, ez);
    check_release(tag);
  endtask

  initial begin
    rst       = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    align_A   = '0;
    align_B   = '0;
    add_sub   = 1'b0;
    sign_res  = 1'b0;
    exp_res   = '0;

    #1;
    check("rst_in_ready",  32'(in_ready),  32'd1);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_data",      {8'(sign_out), 8'(exp_out), 16'(mant_out)}, 32'd0);
    check("rst_flags",     32'({overflow, zero}), 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;

    //     tag          A          B          op    s     exp      lat sign ex       mant       ov    z
    run_op("carry",     23'h400000, 23'h400000, 1'b0, 1'b1, 8'd10,  2, 1'b1, 8'd11,  23'h400000, 1'b0, 1'b0);
    run_op("cancel",    23'h500000, 23'h500000, 1'b1, 1'b1, 8'd50,  2, 1'b0, 8'd0,   23'h000000, 1'b0, 1'b1);
    run_op("normed",    23'h500000, 23'h100000, 1'b1, 1'b0, 8'd100, 2, 1'b0, 8'd100, 23'h400000, 1'b0, 1'b0);
    run_op("deep",      23'h400000, 23'h3FFFFF, 1'b1, 1'b0, 8'd30,  24, 1'b0, 8'd8,  23'h400000, 1'b0, 1'b0);
    // Difference 1 from exponent 3: two shifts reach e=1, leaving 1<<2.
    run_op("underflow", 23'h400000, 23'h3FFFFF, 1'b1, 1'b0, 8'd3,   4, 1'b0, 8'd0,   23'h000004, 1'b0, 1'b0);
    run_op("signflip",  23'h400000, 23'h600000, 1'b1, 1'b0, 8'd20,  3, 1'b1, 8'd19,  23'h400000, 1'b0, 1'b0);
    run_op("overflow",  23'h600000, 23'h600000, 1'b0, 1'b0, 8'd254, 2, 1'b0, 8'd255, 23'h000000, 1'b1, 1'b0);

    // Backpressure: result held while out_ready is low, second operand waits.
    out_ready = 1'b0;
    send(23'h400000, 23'h600000, 1'b1, 1'b0, 8'd20);
    wait_result("bp", 3);
    align_A  = 23'h400000;
    align_B  = 23'h400000;
    add_sub  = 1'b0;
    sign_res = 1'b0;
    exp_res  = 8'd10;
    in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      check_result("bp_hold", 1'b1, 8'd19, 23'h400000, 1'b0, 1'b0);
      @(negedge clk);
    end
    out_ready = 1'b1;
    @(negedge clk);
    check("bp_valid_clr",    32'(out_valid), 32'd0);
    check("bp_ready_ret",    32'(in_ready),  32'd1);
    check("bp_data_held",    32'(mant_out),  32'h400000);
    @(negedge clk);
    in_valid = 1'b0;
    check("bp_second_taken", 32'(in_ready),  32'd0);
    wait_result("bp2", 2);
    check_result("bp2", 1'b0, 8'd11, 23'h400000, 1'b0, 1'b0);
    check_release("bp2");

    // Asynchronous reset in the middle of a long normalization.
    send(23'h400000, 23'h3FFFFF, 1'b1, 1'b0, 8'd30);
    repeat (5) @(negedge clk);
    check("pre_rst_busy", 32'(in_ready), 32'd0);
    #2 rst = 1'b0;
    #1;
    check("arst_in_ready",  32'(in_ready),  32'd1);
    check("arst_out_valid", 32'(out_valid), 32'd0);
    check("arst_data",      {8'(sign_out), 8'(exp_out), 16'(mant_out)}, 32'd0);
    check("arst_mant_hi",   32'(mant_out[M_WIDTH-1:16]), 32'd0);
    check("arst_flags",     32'({overflow, zero}), 32'd0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("post_rst_ready", 32'(in_ready),  32'd1);
    check("post_rst_valid", 32'(out_valid), 32'd0);
    run_op("after_rst", 23'h400000, 23'h600000, 1'b1, 1'b0, 8'd20, 3, 1'b1, 8'd19, 23'h400000, 1'b0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
